// File: rtl/usb_tx_sequencer.sv
// ---------------------------------------------------------------------------
// usb_tx_sequencer
// Transmit packet sequencer for the USB transmit path. It sits between the
// transmit byte FIFO and the bit-stuffing/NRZI controller. A start request
// serializes one packet: SYNC, PID, payload bytes, CRC16 (data PIDs only)
// and EOP. Each bit is paced by the bit-rate strobe, and the sequencer waits
// whenever the stuffer holds it.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-low reset
//   shift_enable one-cycle bit-time strobe
//   stuff_hold   stuffer is inserting a stuffed bit on this strobe
//   tx_start     start request, only honoured while idle
//   tx_pid       PID nibble
//   tx_len       payload byte count (saturates to MAX_BYTES)
//   fifo_empty   transmit FIFO empty
//   fifo_rdata   show-ahead FIFO head byte
//   fifo_read    one-cycle pop, asserted in the cycle of the load edge
//   tx_bit       current serial bit (registered)
//   tx_active    bit stream valid, SYNC through CRC
//   tx_eop       drive SE0
//   tx_busy      sequencer is not idle
//   tx_done      one-cycle pulse at packet end
//   tx_underrun  one-cycle pulse when a byte load finds the FIFO empty
// ---------------------------------------------------------------------------
module usb_tx_sequencer #(
  parameter int MAX_BYTES = 64,
  parameter int LEN_W     = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_enable,
  input  logic             stuff_hold,
  input  logic             tx_start,
  input  logic [3:0]       tx_pid,
  input  logic [LEN_W-1:0] tx_len,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_rdata,
  output logic             fifo_read,
  output logic             tx_bit,
  output logic             tx_active,
  output logic             tx_eop,
  output logic             tx_busy,
  output logic             tx_done,
  output logic             tx_underrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC, S_EOP, S_IDLE_J
  } state_e;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

  state_e           state_q, state_d;
  logic [3:0]       pid_q, pid_d;
  logic [LEN_W-1:0] remain_q, remain_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [15:0]      crc_q, crc_d;
  logic             tx_bit_q, tx_bit_d;
  logic             tx_done_q, tx_done_d;
  logic             adv;
  logic             load_req;

  // Serial CRC16 step, polynomial 0x8005, fed with one departing data bit.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = b ^ c[15];
    return {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
  endfunction

  // State and datapath registers; reset aborts any packet in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pid_q     <= '0;
      remain_q  <= '0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      crc_q     <= '0;
      tx_bit_q  <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pid_q     <= pid_d;
      remain_q  <= remain_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      crc_q     <= crc_d;
      tx_bit_q  <= tx_bit_d;
      tx_done_q <= tx_done_d;
    end
  end

  // Next-state logic. tx_bit_d is always set alongside the shift register
  // (or CRC) so the registered tx_bit tracks the bit on the wire and only
  // moves on an advancing strobe. Byte loads from PID and DATA share the
  // load_req path at the bottom so underrun handling lives in one place.
  always_comb begin
    state_d     = state_q;
    pid_d       = pid_q;
    remain_d    = remain_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    crc_d       = crc_q;
    tx_bit_d    = tx_bit_q;
    tx_done_d   = 1'b0;
    fifo_read   = 1'b0;
    tx_underrun = 1'b0;
    load_req    = 1'b0;
    adv         = shift_enable & ~stuff_hold;

    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          pid_d     = tx_pid;
          remain_d  = (tx_len > MAX_LEN) ? MAX_LEN : tx_len;
          shreg_d   = 8'h80;
          bit_cnt_d = '0;
          crc_d     = 16'hFFFF;
          tx_bit_d  = 1'b0;
          state_d   = S_SYNC;
        end
      end

      S_SYNC: begin
        if (adv) begin
          if (bit_cnt_q == 4'd7) begin
            shreg_d   = {~pid_q, pid_q};
            bit_cnt_d = '0;
            state_d   = S_PID;
          end else begin
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
          tx_bit_d = shreg_d[0];
        end
      end

      S_PID: begin
        if (adv) begin
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            if (pid_q[1:0] == 2'b11) begin
              if (remain_q != '0) begin
                load_req = 1'b1;
              end else begin
                state_d  = S_CRC;
                tx_bit_d = ~crc_q[15];
              end
            end else begin
              shreg_d  = '0;
              tx_bit_d = 1'b0;
              state_d  = S_EOP;
            end
          end else begin
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + 4'd1;
            tx_bit_d  = shreg_d[0];
          end
        end
      end

      S_DATA: begin
        if (adv) begin
          crc_d = crc_step(crc_q, shreg_q[0]);
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            if (remain_q != '0) begin
              load_req = 1'b1;
            end else begin
              state_d  = S_CRC;
              tx_bit_d = ~crc_d[15];
            end
          end else begin
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + 4'd1;
            tx_bit_d  = shreg_d[0];
          end
        end
      end

      // The CRC register is shifted left so its MSB is always the next
      // bit out; the complement is what goes on the wire.
      S_CRC: begin
        if (adv) begin
          if (bit_cnt_q == 4'd15) begin
            bit_cnt_d = '0;
            shreg_d   = '0;
            tx_bit_d  = 1'b0;
            state_d   = S_EOP;
          end else begin
            crc_d     = {crc_q[14:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 4'd1;
            tx_bit_d  = ~crc_d[15];
          end
        end
      end

      S_EOP: begin
        if (shift_enable) begin
          if (bit_cnt_q == 4'd1) begin
            bit_cnt_d = '0;
            state_d   = S_IDLE_J;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end

      S_IDLE_J: begin
        if (shift_enable) begin
          tx_done_d = 1'b1;
          state_d   = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // An empty FIFO at a byte boundary ends the packet early with no CRC.
    if (load_req) begin
      if (fifo_empty) begin
        tx_underrun = 1'b1;
        shreg_d     = '0;
        tx_bit_d    = 1'b0;
        state_d     = S_EOP;
      end else begin
        fifo_read = 1'b1;
        shreg_d   = fifo_rdata;
        remain_d  = remain_q - LEN_W'(1);
        tx_bit_d  = fifo_rdata[0];
        state_d   = S_DATA;
      end
    end
  end

  assign tx_bit    = tx_bit_q;
  assign tx_done   = tx_done_q;
  assign tx_busy   = (state_q != S_IDLE);
  assign tx_eop    = (state_q == S_EOP);
  assign tx_active = (state_q == S_SYNC) || (state_q == S_PID) ||
                     (state_q == S_DATA) || (state_q == S_CRC);

endmodule
